enc8to3_seq: RTL
================

# enc8to3_seq

Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoders. It captures an 8-bit request vector with a valid/ready handshake. It then serializes the vector into a stream of 3-bit indices, one per set bit, in priority order, with last and none flags. It sits downstream of decoded one-hot or multi-hot request lines and feeds index-based consumers: arbiters, interrupt controllers and the decoder round-trip bench.

## Interface
- `MSB_FIRST`, default 0: 0 emits the lowest set index first; 1 emits the highest set index first.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in`, input, 8: request vector.
- `in_valid`, input, 1: `in` is valid.
- `in_ready`, output, 1: block accepts a vector; equals (state == IDLE).
- `out`, output, 3: encoded index of the current beat.
- `out_valid`, output, 1: `out`/`out_last`/`out_none` valid.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_last`, output, 1: final beat of the current vector.
- `out_none`, output, 1: captured vector was all-zero.
- `cnt`, output, 4: popcount of the captured vector. Present only with `ENC8TO3_COUNT_EN`.

## Operation
- State machine, two states.
  - IDLE: `in_ready`=1. `in_valid`=1 captures `in` into `pend[7:0]` and moves to SCAN.
  - SCAN: `out_valid`=1, `in_ready`=0.
- In SCAN, `out` = index of the lowest set bit of `pend` (or highest if `MSB_FIRST`=1).
- `out_last` = 1 when `pend` has at most one bit set.
- A beat transfers when `out_valid` & `out_ready`:
  - the emitted bit of `pend` is cleared;
  - if `out_last`, return to IDLE.
- Zero vector: SCAN produces exactly one beat with `out`=0, `out_none`=1, `out_last`=1.
- When `out_valid`=0, `out`, `out_last` and `out_none` are driven 0.
- Backpressure: while `out_ready`=0, `out`, `out_last`, `out_none`, `out_valid` and `pend` hold stable.
- `in` and `in_valid` are ignored outside IDLE; there is no capture during SCAN.
- Reset values: state=IDLE, `pend`=0, `out_valid`=0, `out`=0, `out_last`=0, `out_none`=0, `in_ready`=1, `cnt`=0.
- Reset mid-SCAN discards `pend`; the cycle after `rst`, the block is in IDLE with no beat pending.
- `rst` has priority over a simultaneous `in_valid` or beat transfer.

## Timing
- Capture on edge N (`in_valid` & `in_ready`): first beat is valid in cycle N+1.
- With `out_ready` held 1, a vector with k set bits yields k beats on consecutive cycles N+1..N+k; a zero vector yields 1 beat.
- After the last beat transfers on edge M, `in_ready`=1 in cycle M+1.
- Throughput: max(k,1)+1 cycles per vector.
- All outputs derive from registers only; there is no combinational path from `in`/`in_valid`/`out_ready` to any output.

## Configuration
- `ENC8TO3_COUNT_EN` defined:
  - `cnt` port exists;
  - it is loaded with popcount(`in`) at capture (0..8) and held through SCAN until the next capture or reset.
- Undefined: no `cnt` port and no popcount logic; all other behaviour is identical.

## Structure
- Shared package `enc8to3_pkg` holds:
  - state encoding (`ST_IDLE`=0, `ST_SCAN`=1);
  - `ENC_IN_W`=8, `ENC_OUT_W`=3, `ENC_CNT_W`=4.
- One combinational sub-module, `enc8to3_pick`:
  - input: 8-bit vector and `MSB_FIRST`;
  - outputs: 3-bit index, one-hot clear mask, single-or-none flag.
- The top level holds the FSM, `pend` and the optional popcount.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 and `in`=8'hFF. Required: `out_valid`=0, `out`=0, `in_ready`=1, and no capture.
- Multi-bit, LSB-first: `in`=8'b0010_0101 for one cycle, `out_ready`=1.
  - Beats `out`=0, 2, 5 on cycles N+1..N+3, with `out_last` only on 5.
  - `in_ready`=1 at N+4.
- Round-trip sweep: `in`=1<<k for k=0..7, mirroring the 3-to-8 decoder sweep. Required: single beat `out`=k, `out_last`=1, `out_none`=0.
- Zero vector and backpressure:
  - `in`=8'h00 gives one beat `out`=0, `out_none`=1, `out_last`=1.
  - `in`=8'h81 with `out_ready`=0 for 3 cycles: `out`=0 held stable, then beats 0 then 7.
  - With `MSB_FIRST`=1, the same 8'h81 vector gives 7 then 0.
- Reset mid-stream and count: `in`=8'hFF, then `rst` after the first beat.
  - The cycle after `rst`, `out_valid`=0 and `in_ready`=1.
  - Recapture 8'hFF with `ENC8TO3_COUNT_EN` defined: `cnt`=8, and 8 beats 0..7 follow.

Source files
------------

// File: rtl/enc8to3_pkg.sv
// enc8to3_pkg: shared definitions for the sequential 8-to-3 encoder.
//   - state_t     : FSM state encoding (ST_IDLE=0, ST_SCAN=1)
//   - ENC_IN_W    : request vector width (8)
//   - ENC_OUT_W   : encoded index width (3)
//   - ENC_CNT_W   : popcount width (4, holds 0..8)
//   - enc_popcount: number of set bits in a request vector
package enc8to3_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;
    localparam int ENC_CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [ENC_CNT_W-1:0] enc_popcount(input logic [ENC_IN_W-1:0] v);
        logic [ENC_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            c = c + {{(ENC_CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/enc8to3_pick.sv
// enc8to3_pick: combinational priority picker.
//   Parameter MSB_FIRST: 0 picks the lowest set bit, 1 picks the highest.
//   vec    (in,  8): pending request bits
//   idx    (out, 3): index of the picked bit (0 when vec is zero)
//   mask   (out, 8): one-hot mask of the picked bit (zero when vec is zero)
//   single (out, 1): vec has at most one bit set
module enc8to3_pick
    import enc8to3_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [ENC_IN_W-1:0]  vec,
    output logic [ENC_OUT_W-1:0] idx,
    output logic [ENC_IN_W-1:0]  mask,
    output logic                 single
);

    always_comb begin
        idx = '0;
        // Scan away from the priority end so the winning bit is the last
        // assignment made.
        if (MSB_FIRST) begin
            for (int i = 0; i < ENC_IN_W; i++) begin
                if (vec[i]) idx = ENC_OUT_W'(i);
            end
        end else begin
            for (int i = ENC_IN_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = ENC_OUT_W'(i);
            end
        end
    end

    always_comb begin
        mask = '0;
        if (vec != '0) mask[idx] = 1'b1;
    end

    // Clearing the lowest set bit leaves zero only for zero- or one-hot vectors.
    assign single = ((vec & (vec - ENC_IN_W'(1))) == '0);

endmodule

// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential 8-to-3 encoder. Captures a request vector with a
// valid/ready handshake and emits one 3-bit index per set bit, in priority
// order, flagging the final beat and the all-zero case.
//   Parameter MSB_FIRST: 0 = lowest index first, 1 = highest index first.
//   clk       (in)    : clock, rising edge
//   rst       (in)    : synchronous active-high reset
//   in        (in, 8) : request vector
//   in_valid  (in)    : in is valid
//   in_ready  (out)   : block is idle and will capture
//   out       (out,3) : index of current beat (0 when out_valid=0)
//   out_valid (out)   : beat present
//   out_ready (in)    : consumer accepts beat
//   out_last  (out)   : final beat of this vector
//   out_none  (out)   : captured vector was all-zero
//   cnt       (out,4) : popcount of captured vector; only when the macro
//                       ENC8TO3_COUNT_EN is defined
// Outputs depend only on state/pend/cnt registers.
module enc8to3_seq
    import enc8to3_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENC_IN_W-1:0]  in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ENC_OUT_W-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_none
`ifdef ENC8TO3_COUNT_EN
    ,
    output logic [ENC_CNT_W-1:0] cnt
`endif
);

    state_t                st, st_nxt;
    logic [ENC_IN_W-1:0]   pend, pend_nxt;
    logic [ENC_OUT_W-1:0]  pick_idx;
    logic [ENC_IN_W-1:0]   pick_mask;
    logic                  pick_single;

    enc8to3_pick #(.MSB_FIRST(MSB_FIRST)) u_pick (
        .vec    (pend),
        .idx    (pick_idx),
        .mask   (pick_mask),
        .single (pick_single)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= ST_IDLE;
            pend <= '0;
        end else begin
            st   <= st_nxt;
            pend <= pend_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        pend_nxt  = pend;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        case (st)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pend_nxt = in;
                    st_nxt   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                out_valid = 1'b1;
                out       = pick_idx;
                // A zero vector still yields one beat (idx 0, single=1).
                out_last  = pick_single;
                out_none  = (pend == '0);
                if (out_ready) begin
                    pend_nxt = pend & ~pick_mask;
                    if (pick_single) st_nxt = ST_IDLE;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

`ifdef ENC8TO3_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (st == ST_IDLE && in_valid) begin
            cnt <= enc_popcount(in);
        end
    end
`endif

endmodule
